// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: 50% duty clock divider, half-period N set through a valid/ready port.
// Define CLKDIV_CNT_EN to add the 16-bit rise_cnt tick counter output.
module clk_div_ctrl #(
   parameter int W       = 8,
   parameter int DIV_RST = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         cfg_valid,
   input  logic [W-1:0] cfg_div,
   output logic         cfg_ready,
   output logic         cfg_err,
   output logic         out_clk,
   output logic         tick,
`ifdef CLKDIV_CNT_EN
   output logic         busy,
   output logic [15:0]  rise_cnt
`else
   output logic         busy
`endif
);
   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
   localparam logic [W-1:0] DIV_INIT = W'(DIV_RST);
   state_t state;
   logic [W-1:0] cnt, div, pdiv;
   logic pend, acc_ok, acc_bad, wrap, fall, to_idle;
   assign cfg_ready = ~pend;
   assign acc_ok    = cfg_valid & ~pend & (cfg_div != '0);
   assign acc_bad   = cfg_valid & ~pend & (cfg_div == '0);
   assign wrap      = cnt == div - 1'b1;
   assign fall      = wrap & out_clk;
   // Stopping always finishes a high phase; a low phase is abandoned at once.
   assign to_idle   = ~en & ((state == RUN & ~out_clk) | fall);
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         div     <= DIV_INIT;
         pdiv    <= '0;
         pend    <= 1'b0;
         out_clk <= 1'b0;
         tick    <= 1'b0;
         cfg_err <= 1'b0;
         busy    <= 1'b0;
      end else begin
         cfg_err <= acc_bad;
         tick    <= 1'b0;
         if (state == IDLE) begin
            if (acc_ok) div <= cfg_div;
            state   <= en ? RUN : IDLE;
            busy    <= en;
            cnt     <= '0;
            out_clk <= 1'b0;
         end else if (to_idle) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            out_clk <= 1'b0;
            pend    <= 1'b0;
            div     <= acc_ok ? cfg_div : pend ? pdiv : div;
         end else begin
            state <= en ? RUN : STOPPING;
            cnt   <= wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
               out_clk <= ~out_clk;
               tick    <= ~out_clk;
            end
            // New ratio takes effect only at the start of a low phase.
            if (fall & pend) begin
               div  <= pdiv;
               pend <= 1'b0;
            end
            if (acc_ok) begin
               pdiv <= cfg_div;
               pend <= 1'b1;
            end
         end
      end
   end
`ifdef CLKDIV_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) rise_cnt <= '0;
      else if (tick) rise_cnt <= rise_cnt + 16'd1;
   end
`endif
endmodule
